// File: rtl/ram_copy_engine.sv
// rtl/ram_copy_engine.sv - COPY/FILL bus master for a single-port synchronous RAM with 1-cycle read latency
module ram_copy_engine #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     mode,
    input  logic [ADDRESS_WIDTH-1:0] src,
    input  logic [ADDRESS_WIDTH-1:0] dst,
    input  logic [ADDRESS_WIDTH:0]   len,
    input  logic [DATA_WIDTH-1:0]    fill_val,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic [ADDRESS_WIDTH:0]   words_done,
    output logic                     mem_wEn,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_dataIn,
    input  logic [DATA_WIDTH-1:0]    mem_dataOut
);
    localparam int AW = ADDRESS_WIDTH;
    localparam logic [AW-1:0] ONE = AW'(1);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_FILL, S_DONE} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [AW:0]     remaining;
    logic            descend;
    logic [DATA_WIDTH-1:0] fill_q;

    logic [AW-1:0]   diff;
    logic            overlap;
    logic            last_word;
    logic [AW-1:0]   len_m1;

    // Forward overlap means an ascending copy would overwrite source words before reading them.
    assign diff      = dst - src;
    assign overlap   = !mode && (diff != '0) && ({1'b0, diff} < len);
    assign last_word = (remaining == {{AW{1'b0}}, 1'b1});
    assign len_m1    = len[AW-1:0] - ONE;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) begin
                if (len == '0)  state_nx = S_DONE;
                else if (mode)  state_nx = S_FILL;
                else            state_nx = S_RD;
            end
            S_RD:    state_nx = abort ? S_DONE : S_WR;
            S_WR:    state_nx = (last_word || abort) ? S_DONE : S_RD;
            S_FILL:  state_nx = (last_word || abort) ? S_DONE : S_FILL;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            remaining  <= '0;
            descend    <= 1'b0;
            fill_q     <= '0;
            words_done <= '0;
            aborted    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (start) begin
                    rd_ptr     <= overlap ? src + len_m1 : src;
                    wr_ptr     <= overlap ? dst + len_m1 : dst;
                    remaining  <= len;
                    descend    <= overlap;
                    fill_q     <= fill_val;
                    words_done <= '0;
                    aborted    <= 1'b0;
                end
                S_RD: if (abort) aborted <= 1'b1;
                S_WR, S_FILL: begin
                    words_done <= words_done + 1'b1;
                    remaining  <= remaining - 1'b1;
                    wr_ptr     <= descend ? wr_ptr - ONE : wr_ptr + ONE;
                    if (state == S_WR)
                        rd_ptr <= descend ? rd_ptr - ONE : rd_ptr + ONE;
                    // A write finishing the command on its last word is a normal completion.
                    if (abort && !last_word) aborted <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy       = (state == S_RD) || (state == S_WR) || (state == S_FILL);
        done       = (state == S_DONE);
        mem_wEn    = (state == S_WR) || (state == S_FILL);
        mem_addr   = '0;
        mem_dataIn = '0;
        case (state)
            S_RD:   mem_addr = rd_ptr;
            S_WR:   begin mem_addr = wr_ptr; mem_dataIn = mem_dataOut; end
            S_FILL: begin mem_addr = wr_ptr; mem_dataIn = fill_q; end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ram_copy_engine.sv
// tb/tb_ram_copy_engine.sv - randomized self-checking bench for ram_copy_engine with a RAM and array reference model
module tb_ram_copy_engine;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [11:0] src = '0;
    logic [11:0] dst = '0;
    logic [12:0] len = '0;
    logic [31:0] fill_val = '0;
    logic        abort = 1'b0;
    logic        busy, done, aborted, mem_wEn;
    logic [12:0] words_done;
    logic [11:0] mem_addr;
    logic [31:0] mem_dataIn, mem_dataOut;

    logic [31:0] ram  [4096];
    logic [31:0] snap [4096];
    logic [31:0] expm [4096];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_copy_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
        .len(len), .fill_val(fill_val), .abort(abort), .busy(busy), .done(done),
        .aborted(aborted), .words_done(words_done), .mem_wEn(mem_wEn),
        .mem_addr(mem_addr), .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
    );

    always @(posedge clk) begin
        if (mem_wEn) ram[mem_addr] <= mem_dataIn;
        mem_dataOut <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // abort_at = n asserts abort during the n-th write; 0 means no abort.
    task automatic run_cmd(input logic m, input logic [11:0] s, input logic [11:0] d,
                           input int n, input logic [31:0] fv, input int abort_at,
                           input bit poke_start);
        int k, cyc, nwr, bad_addr, bad_mem, busy_cnt, exp_cyc;
        bit desc, exp_ab, seen;
        logic [11:0] diff, ea;
        diff = d - s;
        desc = (m == 1'b0) && (diff != 0) && (int'(diff) < n);
        if (abort_at > 0 && abort_at < n) begin k = abort_at; exp_ab = 1'b1; end
        else begin k = n; exp_ab = 1'b0; end
        exp_cyc = (n == 0) ? 1 : (m ? k + 1 : 2 * k + 1);
        for (int i = 0; i < 4096; i++) begin snap[i] = ram[i]; expm[i] = ram[i]; end
        for (int i = 0; i < k; i++) begin
            int j;
            j = desc ? n - 1 - i : i;
            expm[d + 12'(j)] = m ? fv : snap[s + 12'(j)];
        end
        @(negedge clk);
        mode = m; src = s; dst = d; len = 13'(n); fill_val = fv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; nwr = 0; bad_addr = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && cyc <= 9000) begin
            if (done) begin
                seen = 1'b1;
                check("done_cycle", 64'(cyc), 64'(exp_cyc));
                check("busy_in_done", 64'(busy), 64'd0);
                check("aborted", 64'(aborted), 64'(exp_ab));
                check("words_done", 64'(words_done), 64'(k));
            end else begin
                if (mem_wEn) begin
                    ea = desc ? d + 12'(n - 1 - nwr) : d + 12'(nwr);
                    if (mem_addr !== ea) bad_addr++;
                    nwr++;
                    abort = (nwr == abort_at);
                end else begin
                    abort = 1'b0;
                end
                if (busy) busy_cnt++;
                if (poke_start && busy && cyc == 2) begin
                    start = 1'b1; mode = ~m; src = 12'($urandom); dst = 12'($urandom);
                    len = 13'd1; fill_val = 32'hBAD0BAD0;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        abort = 1'b0; start = 1'b0;
        if (!seen) check("done_timeout", 64'd1, 64'd0);
        check("write_count", 64'(nwr), 64'(k));
        check("write_addr_order", 64'(bad_addr), 64'd0);
        check("busy_cycles", 64'(busy_cnt), 64'(m ? k : 2 * k));
        @(negedge clk);
        check("idle_outputs", {60'd0, done, busy, mem_wEn, 1'b0} | 64'(mem_addr), 64'd0);
        bad_mem = 0;
        for (int i = 0; i < 4096; i++) if (ram[i] !== expm[i]) bad_mem++;
        check("mem_contents", 64'(bad_mem), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = $urandom;
        #1;
        check("reset_outputs", {busy, done, aborted, mem_wEn, mem_addr, mem_dataIn, words_done}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_cmd(1'b1, 12'h000, 12'h010, 4, 32'h0000DEAD, 0, 1'b0);
        @(negedge clk); ram[0] = 32'd1; ram[1] = 32'd2; ram[2] = 32'd3;
        run_cmd(1'b0, 12'h000, 12'h100, 3, 32'h0, 0, 1'b0);
        check("copy_word0", 64'(ram[12'h100]), 64'd1);
        check("copy_word2", 64'(ram[12'h102]), 64'd3);
        @(negedge clk); ram[12'h20] = 32'hA; ram[12'h21] = 32'hB; ram[12'h22] = 32'hC; ram[12'h23] = 32'hD;
        run_cmd(1'b0, 12'h020, 12'h021, 4, 32'h0, 0, 1'b0);
        check("overlap_word_hi", 64'(ram[12'h24]), 64'hD);
        check("overlap_word_lo", 64'(ram[12'h21]), 64'hA);
        run_cmd(1'b1, 12'h000, 12'hFFE, 4, 32'h12345678, 0, 1'b0);
        run_cmd(1'b1, 12'h000, 12'h050, 0, 32'hFFFFFFFF, 0, 1'b0);
        run_cmd(1'b0, 12'h200, 12'h300, 8, 32'h0, 3, 1'b1);
        run_cmd(1'b0, 12'h400, 12'h3FE, 5, 32'h0, 5, 1'b0);
        run_cmd(1'b0, 12'h500, 12'h500, 6, 32'h0, 0, 1'b0);
        run_cmd(1'b1, 12'h000, 12'h700, 10, 32'hCAFEF00D, 4, 1'b0);
        run_cmd(1'b1, 12'h000, 12'h123, 4096, 32'h55AA55AA, 0, 1'b0);
        for (int i = 0; i < 4096; i++) ram[i] = $urandom;

        // Reset in the middle of a FILL, away from any clock edge.
        @(negedge clk);
        mode = 1'b1; dst = 12'h600; len = 13'd50; fill_val = 32'h77777777; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {busy, done, aborted, mem_wEn, mem_addr, mem_dataIn, words_done}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        run_cmd(1'b1, 12'h000, 12'h640, 6, 32'h13579BDF, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            logic        m;
            logic [11:0] s, d;
            int          n, ab;
            m = 1'($urandom);
            s = 12'($urandom);
            d = ($urandom_range(0, 2) == 0) ? s + 12'($urandom_range(0, 8)) - 12'd4 : 12'($urandom);
            n = $urandom_range(0, 24);
            ab = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
            run_cmd(m, s, d, n, $urandom, ab, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
